// File: rtl/adc_spi_responder_pkg.sv
// adc_spi_pkg -- shared definitions for the ADC SPI responder.
//   Holds the responder FSM state type, the default frame width and
//   synchronizer depth, and the seed/tap mask of the underrun LFSR that is
//   used when ADC_SPI_RESPONDER_LFSR_EN is defined.
package adc_spi_pkg;

  localparam int DATA_WIDTH_DEFAULT  = 16;
  localparam int SYNC_STAGES_DEFAULT = 2;

  // Fibonacci LFSR: taps 16,14,13,11 (bits 15,13,12,10), feedback into bit 0
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_HOLD
  } spi_state_t;

endpackage

// File: rtl/adc_spi_responder_if.sv
// adc_spi_responder_if -- sample stream and SPI pin bundle of the responder.
//   sample_in/sample_valid_in/sample_ready_out : one-entry sample handshake
//   chip_sel_in/chip_clk_in/chip_data_out      : SPI pins (sel active-low)
//   frame_done_out/underrun_out                : one-cycle status pulses
//   master = sample producer + SPI controller side, slave = responder side.
interface adc_spi_responder_if
  import adc_spi_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
);

  logic [DATA_WIDTH-1:0] sample_in;
  logic                  sample_valid_in;
  logic                  sample_ready_out;
  logic                  chip_sel_in;
  logic                  chip_clk_in;
  logic                  chip_data_out;
  logic                  frame_done_out;
  logic                  underrun_out;

  modport master (
    output sample_in, sample_valid_in, chip_sel_in, chip_clk_in,
    input  sample_ready_out, chip_data_out, frame_done_out, underrun_out
  );

  modport slave (
    input  sample_in, sample_valid_in, chip_sel_in, chip_clk_in,
    output sample_ready_out, chip_data_out, frame_done_out, underrun_out
  );

endinterface

// File: rtl/adc_spi_responder_pin_sync.sv
// spi_pin_sync -- synchronizer and edge detector for one asynchronous pin.
//   clk_in    : system clock
//   rst_in    : synchronous active-high reset (chain loads RESET_LEVEL)
//   pin_in    : asynchronous pin
//   rise_out  : one-cycle pulse on a synchronized rising edge
//   fall_out  : one-cycle pulse on a synchronized falling edge
module spi_pin_sync #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_LEVEL = 1'b0
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic pin_in,
  output logic rise_out,
  output logic fall_out
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] vld_q;
  logic                   prev_q;
  logic                   prev_vld_q;

  // The vld chain travels alongside the data chain so that the reset level
  // is never compared against a real pin value: a pin that already sits
  // opposite to RESET_LEVEL when reset drops does not fake an edge.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      sync_q     <= {SYNC_STAGES{RESET_LEVEL}};
      vld_q      <= '0;
      prev_q     <= RESET_LEVEL;
      prev_vld_q <= 1'b0;
    end else begin
      sync_q[0] <= pin_in;
      vld_q[0]  <= 1'b1;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
        vld_q[i]  <= vld_q[i-1];
      end
      prev_q     <= sync_q[SYNC_STAGES-1];
      prev_vld_q <= vld_q[SYNC_STAGES-1];
    end
  end

  assign rise_out = vld_q[SYNC_STAGES-1] & prev_vld_q &
                    sync_q[SYNC_STAGES-1] & ~prev_q;
  assign fall_out = vld_q[SYNC_STAGES-1] & prev_vld_q &
                    ~sync_q[SYNC_STAGES-1] & prev_q;

endmodule

// File: rtl/adc_spi_responder.sv
// adc_spi_responder -- SPI slave that serves ADC samples MSB first.
//   clk_in : 100 MHz system clock, the only clock
//   rst_in : synchronous active-high reset
//   bus    : adc_spi_responder_if.slave (sample handshake, SPI pins, pulses)
// A one-entry holding buffer accepts samples; each chip_sel falling edge
// moves it into the frame shift register. An empty buffer at frame start
// is an underrun and serves a fill pattern instead.
// Build option ADC_SPI_RESPONDER_LFSR_EN: underrun pattern is the next state
// of a Fibonacci LFSR; without it, the last sample served is repeated.
module adc_spi_responder
  import adc_spi_pkg::*;
#(
  parameter int DATA_WIDTH  = DATA_WIDTH_DEFAULT,
  parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
  input logic              clk_in,
  input logic              rst_in,
  adc_spi_responder_if.slave bus
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);

  spi_state_t            state_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic [DATA_WIDTH-1:0] buf_q;
  logic                  buf_full_q;
  logic [CNT_W-1:0]      bit_cnt_q;
  logic                  data_q;
  logic                  done_q;
  logic                  underrun_q;

  logic                  sel_rise;
  logic                  sel_fall;
  logic                  clk_fall;
  logic                  clk_rise_unused;
  logic                  frame_start;
  logic                  accept;
  logic                  ready;
  logic [DATA_WIDTH-1:0] underrun_word;
  logic [DATA_WIDTH-1:0] frame_word;

  spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_LEVEL(1'b1)) u_sel_sync (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .pin_in   (bus.chip_sel_in),
    .rise_out (sel_rise),
    .fall_out (sel_fall)
  );

  // Rising chip_clk edges carry no meaning for the responder.
  spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_LEVEL(1'b0)) u_clk_sync (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .pin_in   (bus.chip_clk_in),
    .rise_out (clk_rise_unused),
    .fall_out (clk_fall)
  );

  // The buffer empties in the frame-start cycle, so it may take a new sample
  // in that same cycle while the frame takes the old content.
  assign frame_start = (state_q == ST_IDLE) && sel_fall;
  assign ready       = ~buf_full_q | frame_start;
  assign accept      = bus.sample_valid_in & ready;

`ifdef ADC_SPI_RESPONDER_LFSR_EN
  logic [DATA_WIDTH-1:0] lfsr_q;
  logic [DATA_WIDTH-1:0] lfsr_next;

  assign lfsr_next     = {lfsr_q[DATA_WIDTH-2:0],
                          ^(lfsr_q & DATA_WIDTH'(LFSR_TAPS))};
  assign underrun_word = lfsr_next;

  // Advance once per underrun so every empty frame gets a fresh pattern.
  always_ff @(posedge clk_in) begin
    if (rst_in)
      lfsr_q <= DATA_WIDTH'(LFSR_SEED);
    else if (frame_start && !buf_full_q)
      lfsr_q <= lfsr_next;
  end
`else
  logic [DATA_WIDTH-1:0] last_q;

  assign underrun_word = last_q;

  // Remember the most recent real sample so an underrun repeats it.
  always_ff @(posedge clk_in) begin
    if (rst_in)
      last_q <= '0;
    else if (frame_start && buf_full_q)
      last_q <= buf_q;
  end
`endif

  assign frame_word = buf_full_q ? buf_q : underrun_word;

  // One-entry holding buffer; an accept wins over the frame-start drain.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      buf_q      <= '0;
      buf_full_q <= 1'b0;
    end else if (accept) begin
      buf_q      <= bus.sample_in;
      buf_full_q <= 1'b1;
    end else if (frame_start) begin
      buf_full_q <= 1'b0;
    end
  end

  // Frame FSM with registered serial data and status pulses. A chip_sel
  // rise always returns to IDLE; in SHIFT it aborts without frame_done.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      data_q     <= 1'b0;
      done_q     <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      underrun_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          data_q <= 1'b0;
          if (sel_fall) begin
            state_q    <= ST_SHIFT;
            shift_q    <= frame_word;
            data_q     <= frame_word[DATA_WIDTH-1];
            bit_cnt_q  <= '0;
            underrun_q <= ~buf_full_q;
          end
        end
        ST_SHIFT: begin
          if (sel_rise) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            data_q  <= 1'b0;
          end else if (clk_fall) begin
            shift_q   <= {shift_q[DATA_WIDTH-2:0], 1'b0};
            bit_cnt_q <= bit_cnt_q + 1'b1;
            if (bit_cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
              state_q <= ST_HOLD;
              data_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              data_q <= shift_q[DATA_WIDTH-2];
            end
          end
        end
        ST_HOLD: begin
          data_q <= 1'b0;
          if (sel_rise)
            state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
          data_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.sample_ready_out = ready;
  assign bus.chip_data_out    = data_q;
  assign bus.frame_done_out   = done_q;
  assign bus.underrun_out     = underrun_q;

endmodule

// File: tb/tb_adc_spi_responder.sv
// tb_adc_spi_responder -- directed self-checking bench for adc_spi_responder.
//   Acts as sample producer and SPI controller (5-cycle chip_clk half period).
//   Expected frame words are pushed to a scoreboard queue at frame start and
//   popped when the received frame is complete. Honors
//   ADC_SPI_RESPONDER_LFSR_EN for the underrun pattern.
module tb_adc_spi_responder;
  import adc_spi_pkg::*;

  localparam int W    = 16;
  localparam int SYNC = 2;
  localparam int HALF = 5;

  logic clk_in = 1'b0;
  logic rst_in;

  always #5 clk_in = ~clk_in;

  adc_spi_responder_if #(.DATA_WIDTH(W)) bus ();

  adc_spi_responder #(.DATA_WIDTH(W), .SYNC_STAGES(SYNC)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int done_pulses = 0;
  int underrun_pulses = 0;

  logic [W-1:0] exp_q[$];
  logic         model_full;
  logic [W-1:0] model_buf;
`ifdef ADC_SPI_RESPONDER_LFSR_EN
  logic [W-1:0] model_lfsr;
`else
  logic [W-1:0] model_last;
`endif

  logic [W-1:0] rx;
  logic [W-1:0] exp_word;
  logic         exp_underrun;
  int           d0;
  int           u0;
  logic         any_high;

  // Count status pulses away from the active edge.
  always @(negedge clk_in) begin
    if (bus.frame_done_out === 1'b1) done_pulses++;
    if (bus.underrun_out === 1'b1) underrun_pulses++;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [W-1:0] observed,
                              input logic [W-1:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Taps 16,14,13,11 of a left-shifting Fibonacci register.
  function automatic logic [W-1:0] lfsr_step(input logic [W-1:0] s);
    logic fb;
    fb = s[15] ^ s[13] ^ s[12] ^ s[10];
    return {s[14:0], fb};
  endfunction

  task automatic model_reset();
    model_full = 1'b0;
    model_buf  = '0;
`ifdef ADC_SPI_RESPONDER_LFSR_EN
    model_lfsr = LFSR_SEED;
`else
    model_last = '0;
`endif
  endtask

  // Predict what the next frame serves and push it to the scoreboard.
  task automatic model_frame_start(output logic underrun);
    logic [W-1:0] word;
    if (model_full) begin
      word = model_buf;
      underrun = 1'b0;
      model_full = 1'b0;
`ifndef ADC_SPI_RESPONDER_LFSR_EN
      model_last = model_buf;
`endif
    end else begin
      underrun = 1'b1;
`ifdef ADC_SPI_RESPONDER_LFSR_EN
      model_lfsr = lfsr_step(model_lfsr);
      word = model_lfsr;
`else
      word = model_last;
`endif
    end
    exp_q.push_back(word);
  endtask

  // Offer one sample and hold it until the responder takes it.
  task automatic apply_stimulus(input logic [W-1:0] word);
    int guard;
    guard = 0;
    bus.sample_in = word;
    bus.sample_valid_in = 1'b1;
    while (bus.sample_ready_out !== 1'b1 && guard < 50) begin
      tick(1);
      guard++;
    end
    check_output("load_ready", W'(bus.sample_ready_out), W'(1));
    tick(1);
    bus.sample_valid_in = 1'b0;
    model_buf  = word;
    model_full = 1'b1;
  endtask

  // SPI controller: receives nbits, optionally offering a sample in the
  // exact cycle the responder recognises the chip_sel fall.
  task automatic spi_frame(input int nbits, input logic inject,
                           input logic [W-1:0] inj_word,
                           output logic [W-1:0] rx_word);
    rx_word = '0;
    bus.chip_sel_in = 1'b0;
    if (inject) begin
      tick(SYNC);
      bus.sample_in = inj_word;
      bus.sample_valid_in = 1'b1;
      tick(1);
      bus.sample_valid_in = 1'b0;
      tick(6 - SYNC - 1);
    end else begin
      tick(6);
    end
    for (int i = 0; i < nbits; i++) begin
      rx_word = {rx_word[W-2:0], bus.chip_data_out};
      bus.chip_clk_in = 1'b1;
      tick(HALF);
      bus.chip_clk_in = 1'b0;
      tick(HALF);
    end
    tick(HALF);
    bus.chip_sel_in = 1'b1;
    tick(8);
  endtask

  task automatic full_frame(input string tag, input logic inject,
                            input logic [W-1:0] inj_word);
    model_frame_start(exp_underrun);
    if (inject) begin
      model_buf  = inj_word;
      model_full = 1'b1;
    end
    d0 = done_pulses;
    u0 = underrun_pulses;
    spi_frame(W, inject, inj_word, rx);
    exp_word = exp_q.pop_front();
    check_output({tag, "_rx"}, rx, exp_word);
    check_output({tag, "_done"}, W'(done_pulses - d0), W'(1));
    check_output({tag, "_underrun"}, W'(underrun_pulses - u0), W'(exp_underrun));
  endtask

  initial begin
    bus.sample_in       = '0;
    bus.sample_valid_in = 1'b0;
    bus.chip_sel_in     = 1'b1;
    bus.chip_clk_in     = 1'b0;
    rst_in              = 1'b1;
    model_reset();
    tick(3);
    rst_in = 1'b0;
    tick(1);
    $display("[TB] reset state");
    check_output("rst_data", W'(bus.chip_data_out), W'(0));
    check_output("rst_done", W'(bus.frame_done_out), W'(0));
    check_output("rst_underrun", W'(bus.underrun_out), W'(0));
    check_output("rst_ready", W'(bus.sample_ready_out), W'(1));
    tick(5);

    $display("[TB] underrun frames after reset");
    full_frame("underrun1", 1'b0, '0);
    full_frame("underrun2", 1'b0, '0);

    $display("[TB] normal frame A5C3");
    apply_stimulus(16'hA5C3);
    check_output("ready_full", W'(bus.sample_ready_out), W'(0));
    full_frame("a5c3", 1'b0, '0);
    check_output("ready_after", W'(bus.sample_ready_out), W'(1));

    $display("[TB] underrun after a served sample");
    full_frame("underrun3", 1'b0, '0);

    $display("[TB] abort after 7 bits");
    apply_stimulus(16'h0F0F);
    model_frame_start(exp_underrun);
    d0 = done_pulses;
    spi_frame(7, 1'b0, '0, rx);
    exp_word = exp_q.pop_front();
    check_output("abort_bits", {9'b0, rx[6:0]}, exp_word >> 9);
    check_output("abort_done", W'(done_pulses - d0), W'(0));
    check_output("abort_ready", W'(bus.sample_ready_out), W'(1));
    check_output("abort_data", W'(bus.chip_data_out), W'(0));
    apply_stimulus(16'h5A5A);
    full_frame("after_abort", 1'b0, '0);

    $display("[TB] accept in the frame-start cycle");
    apply_stimulus(16'h00FF);
    full_frame("samecycle", 1'b1, 16'h1234);
    check_output("samecycle_ready", W'(bus.sample_ready_out), W'(0));
    full_frame("held_1234", 1'b0, '0);

    $display("[TB] reset mid-frame");
    apply_stimulus(16'hFFFF);
    bus.chip_sel_in = 1'b0;
    tick(6);
    for (int i = 0; i < 9; i++) begin
      bus.chip_clk_in = 1'b1;
      tick(HALF);
      bus.chip_clk_in = 1'b0;
      tick(HALF);
    end
    check_output("prereset_data", W'(bus.chip_data_out), W'(1));
    rst_in = 1'b1;
    tick(1);
    check_output("midrst_data", W'(bus.chip_data_out), W'(0));
    rst_in = 1'b0;
    model_reset();
    d0 = done_pulses;
    u0 = underrun_pulses;
    any_high = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bus.chip_clk_in = 1'b1;
      for (int k = 0; k < HALF; k++) begin
        tick(1);
        any_high = any_high | bus.chip_data_out;
      end
      bus.chip_clk_in = 1'b0;
      for (int k = 0; k < HALF; k++) begin
        tick(1);
        any_high = any_high | bus.chip_data_out;
      end
    end
    check_output("postrst_quiet", W'(any_high), W'(0));
    check_output("postrst_done", W'(done_pulses - d0), W'(0));
    check_output("postrst_underrun", W'(underrun_pulses - u0), W'(0));
    bus.chip_sel_in = 1'b1;
    tick(8);
    check_output("postrst_ready", W'(bus.sample_ready_out), W'(1));
    apply_stimulus(16'hC0DE);
    full_frame("c0de", 1'b0, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
